pipeline_mem_arbiter: RTL and testbench
=======================================

# pipeline_mem_arbiter

Sequencer that shares the datapath's instruction and data memories between the running core and a host requester fed by the software-register block. It drains the pipeline, stalls the core, performs single-word host reads and writes, acknowledges each one, and resumes execution. It sits between the register-interface decode and the memory address, data and write-enable muxes of the 5-stage pipeline.

## Interface
- PC_WIDTH, 9: instruction memory address width.
- DMEM_AW, 8: data memory address width.
- DRAIN_CYCLES, 4: NOP cycles fetched before the stall, one per in-flight stage; must be at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- host_req  in  1  access request; level; held with the fields below stable until host_ack.
- host_hold  in  1  keep the core stalled between accesses (session mode).
- host_sel  in  1  target: 0 = instruction memory, 1 = data memory.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  PC_WIDTH  word address; data memory uses bits [DMEM_AW-1:0].
- host_wdata  in  64  write data; instruction memory uses [31:0].
- host_ack  out  1  one-cycle pulse when the access is complete.
- host_rdata  out  64  read result, valid from host_ack and held until the next ack; instruction reads are zero-extended.
- imem_rdata  in  32  instruction memory read data (1-cycle synchronous read).
- dmem_rdata  in  64  data memory read data (1-cycle synchronous read).
- core_en  out  1  enable for the PC and all pipeline registers.
- fetch_nop  out  1  forces the IF/ID input to 32'h0 (no register write, no memory write).
- imem_host  out  1  instruction memory address, data and we mux select to host.
- dmem_host  out  1  data memory port mux select to host.
- mem_addr  out  PC_WIDTH  host address to the memories.
- mem_wdata  out  64  host write data.
- imem_we  out  1  host instruction memory write strobe.
- dmem_we  out  1  host data memory write strobe.
- busy  out  1  high in every state except RUN.

## Operation
- States: RUN, DRAIN, STALL, ACCESS, RDWAIT, ACK, RESUME.
- RUN: core_en=1 and all other outputs are 0. host_req or host_hold moves to DRAIN and loads drain_cnt=DRAIN_CYCLES-1.
- DRAIN: core_en=1 and fetch_nop=1. drain_cnt decrements each cycle; at 0 the state moves to STALL.
- STALL: core_en=0. If host_req, latch sel/we/addr/wdata and move to ACCESS. Else if !host_hold, move to RESUME. Else stay.
- ACCESS: imem_host or dmem_host per the latched sel, mem_addr and mem_wdata from the latch. imem_we or dmem_we equals the latched we for exactly this one cycle. Next state is RDWAIT.
- RDWAIT: the mux select stays asserted. A read captures imem_rdata or dmem_rdata into host_rdata at the end of this cycle. A write leaves host_rdata unchanged. Next state is ACK.
- ACK: host_ack=1 for one cycle, selects deasserted. Next state is STALL. The host must drop host_req after seeing the ack; a req still high in STALL is treated as a new access.
- RESUME: core_en=0 and fetch_nop=1 for one cycle so the stale IF output is discarded. Next state is RUN.
- The PC is never modified. After a session the core continues from the PC held at the stall.
- host_hold rising during an access does not affect that access.
- Deasserting host_req before ack is illegal; the latched transfer completes regardless.
- Reset in any state: RUN immediately, in-flight access abandoned, no ack. Outputs reset to core_en=1, host_rdata=0, all others 0.

## Timing
- A request sampled high in RUN at cycle T gives DRAIN from T+1 to T+DRAIN_CYCLES, STALL at T+DRAIN_CYCLES+1, and ACCESS at T+DRAIN_CYCLES+2.
- Per access: STALL→ACCESS→RDWAIT→ACK, so host_ack comes 3 cycles after req is sampled in STALL.
- First access ack latency from RUN is DRAIN_CYCLES+4 cycles (8 with the defaults).
- Back-to-back accesses under host_hold: one every 4 cycles.
- All outputs are registered or decoded directly from the state; there is no combinational path from a host input to a memory strobe.

## Configuration
- PIPE_ARB_STATS_EN defined:
  - stall_cycles, 32 bits: counts cycles with core_en=0 and saturates at all-ones.
  - access_count, 16 bits: counts acks and wraps.
  - Both are extra outputs, cleared by reset.
- Undefined: neither counter nor its port exists, and behaviour is otherwise identical.

## Structure
- Shared package:
  - state encoding localparams (3 bits);
  - NOP instruction constant 32'h0;
  - host target encodings IMEM=0 and DMEM=1.
- Sub-module: none required. Under PIPE_ARB_STATS_EN, one small sub-module, pipe_arb_stats, holds both counters.

## Test plan
- Reset mid-ACCESS (dmem write, addr 0x05) → next cycle RUN, core_en=1, dmem_we=0, no host_ack.
- Idle, host_req=0 for 20 cycles → core_en=1, busy=0, fetch_nop=0 throughout.
- dmem write addr 0x12, data 64'hDEAD_BEEF_0123_4567, then read of the same address → write ack at cycle T+8 with dmem_we high exactly 1 cycle; read returns host_rdata=64'hDEAD_BEEF_0123_4567.
- host_hold=1 plus 3 imem writes (addr 0,1,2; data 32'h4000_0000, 32'h4040_0000, 32'h0) → acks 4 cycles apart; core_en stays 0 between them; after hold drops, RESUME lasts 1 cycle and the PC continues from its stall value.
- imem read addr 0x1FF → host_rdata={32'h0, imem[0x1FF]}.
- PIPE_ARB_STATS_EN build, session of 2 accesses → access_count=2; stall_cycles equals the number of cycles with core_en low.

Source files
------------

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types and constants for the pipeline/host memory arbiter.
package pipeline_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_STALL  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RDWAIT = 3'd4,
    ST_ACK    = 3'd5,
    ST_RESUME = 3'd6
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam logic HOST_IMEM = 1'b0;
  localparam logic HOST_DMEM = 1'b1;

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Host request channel between the software-register block and the arbiter.
interface pipeline_mem_arbiter_if #(
  parameter int PC_WIDTH = 9
) ();

  logic                host_req;
  logic                host_hold;
  logic                host_sel;
  logic                host_we;
  logic [PC_WIDTH-1:0] host_addr;
  logic [63:0]         host_wdata;
  logic                host_ack;
  logic [63:0]         host_rdata;

  modport master (
    output host_req, host_hold, host_sel, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_hold, host_sel, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/pipeline_mem_arbiter_stats.sv
// Stall-cycle and access counters; present only when PIPE_ARB_STATS_EN is defined.
`ifdef PIPE_ARB_STATS_EN
module pipe_arb_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_en,
  input  logic        host_ack,
  output logic [31:0] stall_cycles,
  output logic [15:0] access_count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      access_count <= '0;
    end else begin
      if (!core_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (host_ack)
        access_count <= access_count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/pipeline_mem_arbiter.sv
// Drains and stalls the 5-stage pipeline, performs single-word host memory accesses, then resumes.
// Optional counters (stall_cycles, access_count) are built when PIPE_ARB_STATS_EN is defined.
module pipeline_mem_arbiter
  import pipeline_mem_arbiter_pkg::*;
#(
  parameter int PC_WIDTH     = 9,
  parameter int DMEM_AW      = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_mem_arbiter_if.slave host,
  input  logic [31:0]          imem_rdata,
  input  logic [63:0]          dmem_rdata,
  output logic                 core_en,
  output logic                 fetch_nop,
  output logic                 imem_host,
  output logic                 dmem_host,
  output logic [PC_WIDTH-1:0]  mem_addr,
  output logic [63:0]          mem_wdata,
  output logic                 imem_we,
  output logic                 dmem_we,
  output logic                 busy
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          access_count
`endif
);

  localparam int DRAIN_CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // Address bits above the data memory's width never reach the data memory port.
  localparam logic [PC_WIDTH-1:0] DMEM_MASK = PC_WIDTH'((64'd1 << DMEM_AW) - 64'd1);

  arb_state_t          state, state_nxt;
  logic [DRAIN_CW-1:0] drain_cnt;
  logic                lat_sel;
  logic                lat_we;
  logic [PC_WIDTH-1:0] lat_addr;
  logic [63:0]         lat_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      drain_cnt       <= '0;
      lat_sel         <= HOST_IMEM;
      lat_we          <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      host.host_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_RUN: begin
          if (host.host_req || host.host_hold)
            drain_cnt <= DRAIN_CW'(DRAIN_CYCLES - 1);
        end
        ST_DRAIN: begin
          if (drain_cnt != '0)
            drain_cnt <= drain_cnt - DRAIN_CW'(1);
        end
        ST_STALL: begin
          if (host.host_req) begin
            lat_sel   <= host.host_sel;
            lat_we    <= host.host_we;
            lat_addr  <= host.host_addr;
            lat_wdata <= host.host_wdata;
          end
        end
        ST_RDWAIT: begin
          if (!lat_we)
            host.host_rdata <= (lat_sel == HOST_DMEM) ? dmem_rdata : {32'h0, imem_rdata};
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of the state plus latched fields; no host input reaches a strobe.
  always_comb begin
    state_nxt     = state;
    core_en       = 1'b0;
    fetch_nop     = 1'b0;
    imem_host     = 1'b0;
    dmem_host     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    imem_we       = 1'b0;
    dmem_we       = 1'b0;
    busy          = 1'b1;
    host.host_ack = 1'b0;

    case (state)
      ST_RUN: begin
        core_en = 1'b1;
        busy    = 1'b0;
        if (host.host_req || host.host_hold)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        core_en   = 1'b1;
        fetch_nop = 1'b1;
        if (drain_cnt == '0)
          state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (host.host_req)
          state_nxt = ST_ACCESS;
        else if (!host.host_hold)
          state_nxt = ST_RESUME;
      end
      ST_ACCESS, ST_RDWAIT: begin
        imem_host = (lat_sel == HOST_IMEM);
        dmem_host = (lat_sel == HOST_DMEM);
        mem_addr  = (lat_sel == HOST_DMEM) ? (lat_addr & DMEM_MASK) : lat_addr;
        mem_wdata = lat_wdata;
        if (state == ST_ACCESS) begin
          imem_we   = lat_we && (lat_sel == HOST_IMEM);
          dmem_we   = lat_we && (lat_sel == HOST_DMEM);
          state_nxt = ST_RDWAIT;
        end else begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        host.host_ack = 1'b1;
        state_nxt     = ST_STALL;
      end
      ST_RESUME: begin
        fetch_nop = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

`ifdef PIPE_ARB_STATS_EN
  pipe_arb_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_en      (core_en),
    .host_ack     (host.host_ack),
    .stall_cycles (stall_cycles),
    .access_count (access_count)
  );
`endif

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench: schedule-based reference model, bench-side memories, directed and random host traffic.
module tb_pipeline_mem_arbiter;
  import pipeline_mem_arbiter_pkg::*;

  localparam int PC_WIDTH     = 9;
  localparam int DMEM_AW      = 8;
  localparam int DRAIN_CYCLES = 4;
  localparam int TIMEOUT      = 60;
  localparam logic [PC_WIDTH-1:0] DMASK = 9'h0FF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0]         imem_rdata;
  logic [63:0]         dmem_rdata;
  logic                core_en, fetch_nop, imem_host, dmem_host, imem_we, dmem_we, busy;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [63:0]         mem_wdata;
`ifdef PIPE_ARB_STATS_EN
  logic [31:0]         stall_cycles;
  logic [15:0]         access_count;
`endif

  pipeline_mem_arbiter_if #(.PC_WIDTH(PC_WIDTH)) hif ();

  pipeline_mem_arbiter #(
    .PC_WIDTH     (PC_WIDTH),
    .DMEM_AW      (DMEM_AW),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (hif),
    .imem_rdata   (imem_rdata),
    .dmem_rdata   (dmem_rdata),
    .core_en      (core_en),
    .fetch_nop    (fetch_nop),
    .imem_host    (imem_host),
    .dmem_host    (dmem_host),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .imem_we      (imem_we),
    .dmem_we      (dmem_we),
    .busy         (busy)
`ifdef PIPE_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .access_count (access_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int unsigned i);
    logic [31:0] v;
    v = 32'(i);
    return {(v * 32'h9E37_79B9) ^ 32'h1234_5678, (~v) * 32'h85EB_CA6B};
  endfunction

  function automatic logic [31:0] init_iword(input int unsigned i);
    logic [63:0] w;
    w = init_word(i);
    return (i == 511) ? 32'hCAFE_F00D : w[31:0];
  endfunction

  // Bench-side memories with 1-cycle synchronous read, driven by the arbiter's host port.
  logic [31:0] imem_mem [512];
  logic [63:0] dmem_mem [256];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) imem_mem[i] <= init_iword(i);
      for (int i = 0; i < 256; i++) dmem_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (imem_we === 1'b1) imem_mem[mem_addr] <= mem_wdata[31:0];
      if (dmem_we === 1'b1) dmem_mem[mem_addr[DMEM_AW-1:0]] <= mem_wdata;
    end
    imem_rdata <= imem_mem[mem_addr];
    dmem_rdata <= dmem_mem[mem_addr[DMEM_AW-1:0]];
  end

  // Reference model: a queue of per-cycle expected outputs, refilled only on rest cycles.
  typedef struct packed {
    logic                core_en;
    logic                fetch_nop;
    logic                imem_host;
    logic                dmem_host;
    logic                imem_we;
    logic                dmem_we;
    logic                ack;
    logic                busy;
    logic [PC_WIDTH-1:0] addr;
    logic [63:0]         wdata;
    logic                rd_upd;
    logic [63:0]         rd_val;
  } exp_t;

  exp_t        sched[$];
  exp_t        cur;
  bit          parked;
  bit          model_live = 1'b0;
  logic [63:0] exp_rdata;
  logic [31:0] exp_stall;
  logic [15:0] exp_acc;
  logic [31:0] ref_imem [512];
  logic [63:0] ref_dmem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned pc = 0, ce_low_cnt = 0, dwe_cnt = 0, resume_cnt = 0, ack_cnt = 0;

  function automatic exp_t mk(input bit ce, input bit fn, input bit bsy);
    exp_t e;
    e = '0;
    e.core_en   = ce;
    e.fetch_nop = fn;
    e.busy      = bsy;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t a, r, k;
    logic [DMEM_AW-1:0] di;
    if (!rst_n) begin
      if (!model_live) begin
        for (int i = 0; i < 512; i++) ref_imem[i] = init_iword(i);
        for (int i = 0; i < 256; i++) ref_dmem[i] = init_word(i);
      end
      sched.delete();
      parked     = 1'b0;
      exp_rdata  = '0;
      exp_stall  = '0;
      exp_acc    = '0;
      cur        = mk(1, 0, 0);
      model_live = 1'b1;
    end else if (model_live) begin
      if (!cur.core_en && exp_stall != '1) exp_stall++;
      if (cur.ack) exp_acc++;
      if (sched.size() == 0) begin
        if (!parked) begin
          if (hif.host_req || hif.host_hold) begin
            for (int i = 0; i < DRAIN_CYCLES; i++) sched.push_back(mk(1, 1, 1));
            sched.push_back(mk(0, 0, 1));
            parked = 1'b1;
          end
        end else if (hif.host_req) begin
          di = hif.host_addr[DMEM_AW-1:0];
          a = mk(0, 0, 1);
          a.imem_host = !hif.host_sel;
          a.dmem_host = hif.host_sel;
          a.addr      = hif.host_sel ? (hif.host_addr & DMASK) : hif.host_addr;
          a.wdata     = hif.host_wdata;
          r = a;
          a.imem_we   = hif.host_we && !hif.host_sel;
          a.dmem_we   = hif.host_we && hif.host_sel;
          k = mk(0, 0, 1);
          k.ack    = 1'b1;
          k.rd_upd = !hif.host_we;
          k.rd_val = hif.host_sel ? ref_dmem[di] : {32'h0, ref_imem[hif.host_addr]};
          if (hif.host_we) begin
            if (hif.host_sel) ref_dmem[di] = hif.host_wdata;
            else              ref_imem[hif.host_addr] = hif.host_wdata[31:0];
          end
          sched.push_back(a);
          sched.push_back(r);
          sched.push_back(k);
          sched.push_back(mk(0, 0, 1));
        end else if (!hif.host_hold) begin
          sched.push_back(mk(0, 1, 1));
          sched.push_back(mk(1, 0, 0));
          parked = 1'b0;
        end
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = parked ? mk(0, 0, 1) : mk(1, 0, 0);
      if (cur.rd_upd) exp_rdata = cur.rd_val;
    end
  endtask

  task automatic compare_step();
    if (model_live) begin
      chk("core_en",    core_en,        cur.core_en);
      chk("fetch_nop",  fetch_nop,      cur.fetch_nop);
      chk("imem_host",  imem_host,      cur.imem_host);
      chk("dmem_host",  dmem_host,      cur.dmem_host);
      chk("imem_we",    imem_we,        cur.imem_we);
      chk("dmem_we",    dmem_we,        cur.dmem_we);
      chk("host_ack",   hif.host_ack,   cur.ack);
      chk("busy",       busy,           cur.busy);
      chk("host_rdata", hif.host_rdata, exp_rdata);
      if (cur.imem_host || cur.dmem_host) begin
        chk("mem_addr",  mem_addr,  cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
`ifdef PIPE_ARB_STATS_EN
      chk("stall_cycles", stall_cycles, exp_stall);
      chk("access_count", access_count, exp_acc);
`endif
      if (core_en === 1'b1) pc++; else ce_low_cnt++;
      if (dmem_we === 1'b1) dwe_cnt++;
      if (fetch_nop === 1'b1 && core_en === 1'b0) resume_cnt++;
      if (hif.host_ack === 1'b1) ack_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic sel, input logic we, input logic [PC_WIDTH-1:0] addr,
                           input logic [63:0] wd, input int hold_at,
                           output int lat, output logic [63:0] rd);
    hif.host_sel   = sel;
    hif.host_we    = we;
    hif.host_addr  = addr;
    hif.host_wdata = wd;
    hif.host_req   = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (hold_at != 0 && lat == hold_at) hif.host_hold = 1'b1;
    end while (hif.host_ack !== 1'b1 && lat < TIMEOUT);
    chk("ack_seen", hif.host_ack, 1);
    hif.host_req = 1'b0;
    rd = hif.host_rdata;
  endtask

  initial begin
    int          lat, bad, mode, n, n_iter;
    logic [63:0] rd;
    int unsigned ce0, r0, d0, a0, pc_stall;
`ifdef PIPE_ARB_STATS_EN
    logic [31:0] sc0;
    logic [15:0] ac0;
`endif
    hif.host_req   = 1'b0;
    hif.host_hold  = 1'b0;
    hif.host_sel   = 1'b0;
    hif.host_we    = 1'b0;
    hif.host_addr  = '0;
    hif.host_wdata = '0;

    fork
      forever begin @(posedge clk); model_step();   end
      forever begin @(negedge clk); compare_step(); end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_core_en",    core_en,        1);
    chk("rst_busy",       busy,           0);
    chk("rst_fetch_nop",  fetch_nop,      0);
    chk("rst_host_rdata", hif.host_rdata, 0);
    chk("rst_strobes",    {imem_we, dmem_we, imem_host, dmem_host, hif.host_ack}, 0);

    bad = 0;
    repeat (20) begin
      tick();
      if (core_en !== 1'b1 || busy !== 1'b0 || fetch_nop !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    d0 = dwe_cnt;
    do_access(HOST_DMEM, 1'b1, 9'h012, 64'hDEAD_BEEF_0123_4567, 0, lat, rd);
    chk("wr_ack_latency", lat, 8);
    chk("dmem_we_width", dwe_cnt - d0, 1);
    repeat (3) tick();
    do_access(HOST_DMEM, 1'b0, 9'h012, 64'h0, 0, lat, rd);
    chk("rd_ack_latency", lat, 8);
    chk("dmem_readback", rd, 64'hDEAD_BEEF_0123_4567);
    repeat (3) tick();

    ce0 = ce_low_cnt;
    r0  = resume_cnt;
    hif.host_hold = 1'b1;
    do_access(HOST_IMEM, 1'b1, 9'h000, 64'h0000_0000_4000_0000, 0, lat, rd);
    chk("session_first_latency", lat, 8);
    pc_stall = pc;
    tick();
    do_access(HOST_IMEM, 1'b1, 9'h001, 64'h0000_0000_4040_0000, 0, lat, rd);
    chk("hold_ack_gap", lat + 1, 4);
    tick();
    do_access(HOST_IMEM, 1'b1, 9'h002, 64'h0, 0, lat, rd);
    chk("hold_ack_gap", lat + 1, 4);
    hif.host_hold = 1'b0;
    repeat (3) tick();
    chk("session_core_en_low", ce_low_cnt - ce0, 14);
    chk("resume_cycles", resume_cnt - r0, 1);
    chk("pc_held", pc, pc_stall);
    chk("back_in_run", {core_en, busy}, 2'b10);

    // hold rises mid-access: the access completes normally and the core stays parked afterwards
    do_access(HOST_IMEM, 1'b0, 9'h1FF, 64'h0, 6, lat, rd);
    chk("imem_top_latency", lat, 8);
    chk("imem_top_read", rd, 64'h0000_0000_CAFE_F00D);
    tick();
    chk("hold_keeps_stall", {core_en, busy}, 2'b01);
    do_access(HOST_IMEM, 1'b0, 9'h001, 64'h0, 0, lat, rd);
    chk("imem_readback", rd, 64'h0000_0000_4040_0000);
    hif.host_hold = 1'b0;
    repeat (3) tick();

    hif.host_sel   = HOST_DMEM;
    hif.host_we    = 1'b1;
    hif.host_addr  = 9'h005;
    hif.host_wdata = {$urandom, $urandom};
    hif.host_req   = 1'b1;
    n = 0;
    while (dmem_we !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
    chk("reach_access", dmem_we, 1);
    rst_n        = 1'b0;
    hif.host_req = 1'b0;
    a0 = ack_cnt;
    tick();
    chk("mid_rst_core_en", core_en, 1);
    chk("mid_rst_dmem_we", dmem_we, 0);
    chk("mid_rst_ack",     hif.host_ack, 0);
    chk("mid_rst_busy",    busy, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("no_ack_after_reset", ack_cnt - a0, 0);

`ifdef PIPE_ARB_STATS_EN
    sc0 = stall_cycles;
    ac0 = access_count;
    hif.host_hold = 1'b1;
    do_access(HOST_DMEM, 1'b1, 9'h033, 64'h1111_2222_3333_4444, 0, lat, rd);
    tick();
    do_access(HOST_DMEM, 1'b0, 9'h033, 64'h0, 0, lat, rd);
    hif.host_hold = 1'b0;
    repeat (3) tick();
    chk("stats_access_count", 64'(access_count - ac0), 2);
    chk("stats_stall_cycles", 64'(stall_cycles - sc0), 10);
`endif

    n_iter = 40;
    for (int it = 0; it < n_iter; it++) begin
      repeat ($urandom_range(0, 4)) tick();
      mode = $urandom_range(0, 2);
      n    = (mode == 0) ? 1 : $urandom_range(1, 3);
      if (mode != 0) hif.host_hold = 1'b1;
      if (mode == 2) repeat ($urandom_range(1, 8)) tick();
      for (int j = 0; j < n; j++) begin
        if (j > 0) repeat ($urandom_range(1, 3)) tick();
        do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  PC_WIDTH'($urandom_range(0, 511)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 6 : 0, lat, rd);
      end
      hif.host_hold = 1'b0;
    end
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
